// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with stall, absolute/relative branch redirect and halt
// Ports:
//   clk, reset            - single clock, synchronous active-high reset
//   address               - fetch address to program memory (current pc)
//   instruction_code      - word returned combinationally by program memory
//   instr, instr_pc       - registered instruction and the address it came from
//   instr_valid           - instr/instr_pc hold a live instruction
//   instr_ready           - decoder accepts instr this cycle
//   branch_taken          - consumed instruction redirects the pc
//   branch_relative       - 1: target = instr_pc + 1 + branch_value, 0: target = branch_value
//   branch_value          - absolute target or two's-complement offset
//   halt_req              - consumed instruction stops fetching (wins over branch_taken)
//   halted                - unit is in the HALTED state
module fetch_unit #(
    parameter int program_code_size = 8,
    parameter int instruction_size  = 24
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [program_code_size-1:0] address,
    input  logic [instruction_size-1:0]  instruction_code,
    output logic [instruction_size-1:0]  instr,
    output logic [program_code_size-1:0] instr_pc,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    input  logic                         branch_taken,
    input  logic                         branch_relative,
    input  logic [program_code_size-1:0] branch_value,
    input  logic                         halt_req,
    output logic                         halted
);
    localparam logic [0:0] st_fetch  = 1'b0;
    localparam logic [0:0] st_halted = 1'b1;
    logic [0:0]                   r_state;
    logic [program_code_size-1:0] r_pc;
    logic                         w_xfer;
    logic [program_code_size-1:0] w_target;
    assign address  = r_pc;
    assign w_xfer   = instr_valid & instr_ready;
    // Width of the sum is the pc width, so relative targets wrap like the pc does
    assign w_target = branch_relative ? instr_pc + 1'b1 + branch_value : branch_value;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= st_fetch;
            r_pc        <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else if (r_state == st_fetch) begin
            if (w_xfer && halt_req) begin
                r_state     <= st_halted;
                halted      <= 1'b1;
                instr_valid <= 1'b0;
                r_pc        <= instr_pc + 1'b1;
            end else if (w_xfer && branch_taken) begin
                // The sequential word on the bus now is discarded: one bubble
                r_pc        <= w_target;
                instr_valid <= 1'b0;
            end else if (!instr_valid || instr_ready) begin
                instr       <= instruction_code;
                instr_pc    <= r_pc;
                instr_valid <= 1'b1;
                r_pc        <= r_pc + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven directed check of fetch_unit plus a sequential wrap run
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  address;
    logic [23:0] instruction_code;
    logic [23:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_taken;
    logic        branch_relative;
    logic [7:0]  branch_value;
    logic        halt_req;
    logic        halted;
    int          n_chk = 0;
    int          n_pass = 0;
    typedef struct {
        logic       rst, rdy, bt, br, hr;
        logic [7:0] bv;
        logic       ev;
        logic [7:0] epc, ea;
        logic       eh;
    } vec_t;
    vec_t q[$];
    always #5 clk = ~clk;
    function automatic logic [23:0] mem(input logic [7:0] a);
        return {a ^ 8'h5A, ~a, a + 8'h11};
    endfunction
    assign instruction_code = mem(address);
    fetch_unit #(.program_code_size(8), .instruction_size(24)) dut (
        .clk(clk), .reset(reset), .address(address), .instruction_code(instruction_code),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .branch_taken(branch_taken), .branch_relative(branch_relative), .branch_value(branch_value),
        .halt_req(halt_req), .halted(halted)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask
    task automatic add(input logic rst, rdy, bt, br, hr, input logic [7:0] bv,
                       input logic ev, input logic [7:0] epc, ea, input logic eh);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.bt = bt; v.br = br; v.hr = hr; v.bv = bv;
        v.ev = ev; v.epc = epc; v.ea = ea; v.eh = eh;
        q.push_back(v);
    endtask
    task automatic drive(input logic rst, rdy, bt, br, hr, input logic [7:0] bv);
        @(negedge clk);
        reset = rst; instr_ready = rdy; branch_taken = bt;
        branch_relative = br; halt_req = hr; branch_value = bv;
        @(posedge clk);
        #1;
    endtask
    initial begin
        logic [23:0] exp_instr;
        reset = 1'b1; instr_ready = 1'b0; branch_taken = 1'b0;
        branch_relative = 1'b0; halt_req = 1'b0; branch_value = 8'h00;
        exp_instr = '0;
        //   rst rdy bt br hr bv      ev epc    addr   halted
        add(1, 0, 0, 0, 0, 8'h00,  0, 8'h00, 8'h00, 0);
        add(1, 1, 1, 0, 1, 8'h00,  0, 8'h00, 8'h00, 0);
        add(0, 1, 0, 0, 0, 8'h00,  1, 8'h00, 8'h01, 0);
        add(0, 1, 0, 0, 0, 8'h00,  1, 8'h01, 8'h02, 0);
        add(0, 1, 0, 0, 0, 8'h00,  1, 8'h02, 8'h03, 0);
        add(0, 1, 0, 0, 0, 8'h00,  1, 8'h03, 8'h04, 0);
        add(0, 1, 1, 0, 0, 8'h40,  0, 8'h03, 8'h40, 0);
        add(0, 1, 1, 0, 0, 8'h99,  1, 8'h40, 8'h41, 0);
        add(0, 1, 1, 0, 0, 8'h05,  0, 8'h40, 8'h05, 0);
        add(0, 1, 0, 0, 0, 8'h00,  1, 8'h05, 8'h06, 0);
        add(0, 0, 1, 0, 1, 8'h20,  1, 8'h05, 8'h06, 0);
        add(0, 0, 0, 0, 0, 8'h00,  1, 8'h05, 8'h06, 0);
        add(0, 0, 1, 1, 0, 8'h20,  1, 8'h05, 8'h06, 0);
        add(0, 1, 0, 0, 0, 8'h00,  1, 8'h06, 8'h07, 0);
        add(0, 1, 0, 0, 0, 8'h00,  1, 8'h07, 8'h08, 0);
        add(0, 1, 1, 0, 1, 8'h40,  0, 8'h07, 8'h08, 1);
        for (int i = 0; i < 10; i++)
            add(0, i[0], 1, i[1], 1, 8'h30, 0, 8'h07, 8'h08, 1);
        add(1, 1, 0, 0, 0, 8'h00,  0, 8'h00, 8'h00, 0);
        add(0, 1, 0, 0, 0, 8'h00,  1, 8'h00, 8'h01, 0);
        add(0, 1, 1, 0, 0, 8'hFE,  0, 8'h00, 8'hFE, 0);
        add(0, 1, 0, 0, 0, 8'h00,  1, 8'hFE, 8'hFF, 0);
        add(0, 1, 1, 1, 0, 8'h03,  0, 8'hFE, 8'h02, 0);
        add(0, 1, 0, 0, 0, 8'h00,  1, 8'h02, 8'h03, 0);
        add(0, 1, 1, 0, 0, 8'hFF,  0, 8'h02, 8'hFF, 0);
        add(0, 1, 0, 0, 0, 8'h00,  1, 8'hFF, 8'h00, 0);
        add(0, 1, 0, 0, 0, 8'h00,  1, 8'h00, 8'h01, 0);
        add(0, 1, 0, 0, 0, 8'h00,  1, 8'h01, 8'h02, 0);
        add(0, 0, 0, 0, 0, 8'h00,  1, 8'h01, 8'h02, 0);
        add(1, 0, 1, 0, 1, 8'h55,  0, 8'h00, 8'h00, 0);
        add(0, 0, 0, 0, 0, 8'h00,  1, 8'h00, 8'h01, 0);
        add(0, 0, 0, 0, 0, 8'h00,  1, 8'h00, 8'h01, 0);
        add(0, 1, 1, 0, 0, 8'h80,  0, 8'h00, 8'h80, 0);
        add(1, 1, 0, 0, 0, 8'h00,  0, 8'h00, 8'h00, 0);
        add(0, 1, 0, 0, 0, 8'h00,  1, 8'h00, 8'h01, 0);
        foreach (q[i]) begin
            drive(q[i].rst, q[i].rdy, q[i].bt, q[i].br, q[i].hr, q[i].bv);
            exp_instr = q[i].rst ? 24'h0 : q[i].ev ? mem(q[i].epc) : exp_instr;
            chk($sformatf("row%0d valid", i), {31'b0, instr_valid}, {31'b0, q[i].ev});
            chk($sformatf("row%0d instr_pc", i), {24'b0, instr_pc}, {24'b0, q[i].epc});
            chk($sformatf("row%0d address", i), {24'b0, address}, {24'b0, q[i].ea});
            chk($sformatf("row%0d halted", i), {31'b0, halted}, {31'b0, q[i].eh});
            chk($sformatf("row%0d instr", i), {8'b0, instr}, {8'b0, exp_instr});
        end
        drive(1, 1, 0, 0, 0, 8'h00);
        drive(1, 1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 260; i++) begin
            logic [7:0] a;
            a = i[7:0];
            drive(0, 1, 0, 0, 0, 8'h00);
            chk($sformatf("seq%0d valid", i), {31'b0, instr_valid}, 32'd1);
            chk($sformatf("seq%0d instr_pc", i), {24'b0, instr_pc}, {24'b0, a});
            chk($sformatf("seq%0d instr", i), {8'b0, instr}, {8'b0, mem(a)});
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter program_code_size, default 8, program address width in bits (matches program_memory).
REQ-002 Parameter instruction_size, default 24, instruction word width in bits (matches program_memory).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
REQ-005 address  output  program_code_size  fetch address to program_memory; equals current pc, combinational from pc register.
REQ-006 instruction_code  input  instruction_size  word returned combinationally by program_memory for address.
REQ-007 instr  output  instruction_size  registered instruction presented to decoder.
REQ-008 instr_pc  output  program_code_size  address from which instr was fetched.
REQ-009 instr_valid  output  1  instr/instr_pc hold a live instruction.
REQ-010 instr_ready  input  1  decoder accepts instr this cycle.
REQ-011 branch_taken  input  1  consumed instruction redirects the pc.
REQ-012 branch_relative  input  1  1: target = instr_pc + 1 + branch_value; 0: target = branch_value.
REQ-013 branch_value  input  program_code_size  absolute target or two's-complement offset.
REQ-014 halt_req  input  1  consumed instruction stops fetching.
REQ-015 halted  output  1  unit is in HALTED state.

Function
REQ-016 States: FETCH, HALTED; reset enters FETCH.
REQ-017 Transfer occurs on a rising edge where instr_valid=1 and instr_ready=1; branch_taken and halt_req are sampled only on a transfer, ignored otherwise.
REQ-018 Load condition (FETCH, no redirect, no halt): instr_valid=0 or instr_ready=1 -> instr<=instruction_code, instr_pc<=pc, instr_valid<=1, pc<=pc+1.
REQ-019 Stall: instr_valid=1, instr_ready=0 -> pc, instr, instr_pc, instr_valid all hold.
REQ-020 Branch: transfer with branch_taken=1, halt_req=0 -> pc<=target, instr_valid<=0 (sequential instruction discarded); fetch from target on the next edge; exactly one bubble cycle.
REQ-021 All pc arithmetic modulo 2^program_code_size; pc 2^program_code_size-1 increments to 0; relative targets wrap identically.
REQ-022 Halt: transfer with halt_req=1 -> state HALTED, instr_valid<=0, pc<=instr_pc+1; halt_req has priority over branch_taken.
REQ-023 HALTED: no loads, pc/instr/instr_pc hold, instr_valid=0, halted=1; only reset exits.
REQ-024 halted is a registered decode of state; 0 in FETCH.
REQ-025 Throughput: with instr_ready held 1 and no branches, one instruction per cycle, instr_pc increments by 1 each cycle.
REQ-026 address always reflects the pc register, including during stall, bubble and HALTED.

Reset
REQ-027 reset=1 at a rising edge -> pc=0, instr=0, instr_pc=0, instr_valid=0, halted=0, state FETCH, overriding all other inputs.
REQ-028 Reset asserted mid-stall, mid-branch or in HALTED discards pending state with the same values as REQ-027.
REQ-029 First edge with reset=0 loads instruction at address 0; instr_valid=1 after that edge.

Verification
REQ-030 Sequential run: prog.hex loaded, reset 2 cycles, instr_ready=1 -> instr_pc 0,1,2,... each cycle, instr == memory[instr_pc] every valid cycle.
REQ-031 Stall: instr_valid=1 at instr_pc=5, instr_ready=0 for 3 cycles -> instr, instr_pc=5 held, address=6 held; instr_ready=1 -> instr_pc=6 next cycle.
REQ-032 Absolute branch: transfer at instr_pc=3, branch_taken=1, branch_relative=0, branch_value=8'h40 -> one cycle instr_valid=0, then instr_pc=8'h40.
REQ-033 Relative branch with wrap: transfer at instr_pc=8'hFE, branch_relative=1, branch_value=8'h03 -> next valid instr_pc=8'h02; sequential wrap: instr_pc 8'hFF followed by 8'h00.
REQ-034 Halt priority: transfer at instr_pc=7 with halt_req=1 and branch_taken=1 -> halted=1, instr_valid=0, address=8, held for 10 cycles; reset -> halted=0, instr_pc=0 after first load.
REQ-035 Reset mid-stall: instr_valid=1, instr_ready=0, reset=1 -> all outputs per REQ-027 at the next edge.
